// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - size and state encodings shared by the MIPS memory stage
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - big-endian lane extraction/extension for loads, byte enables and lane replication for stores
module dmem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane 0 is the most significant byte, so the shift distance is (3 - lane) bytes.
  assign byte_v = 8'(rdata_i >> {~lane_i, 3'b000});
  assign half_v = lane_i[1] ? rdata_i[15:0] : rdata_i[31:16];

  always_comb begin
    load_data_o = '0;
    be_o        = '0;
    wdata_rep_o = '0;
    case (size_i)
      SZ_BYTE: begin
        load_data_o = unsigned_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
        be_o        = 4'b1000 >> lane_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        load_data_o = unsigned_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
        be_o        = lane_i[1] ? 4'b0011 : 4'b1100;
        wdata_rep_o = {2{wdata_i[15:0]}};
      end
      SZ_WORD: begin
        load_data_o = rdata_i;
        be_o        = 4'b1111;
        wdata_rep_o = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// rtl/dmem_bytelane.sv - MEM-stage data memory with byte-lane access, 1-cycle registered response and post-reset clear
module dmem_bytelane
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W         = 9,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  logic [31:0] mem [DEPTH];

  mem_state_e       state_q;
  logic [IDX_W-1:0] idx_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_rdata_q;
  logic             rsp_err_q;

  logic             accept;
  logic [IDX_W-1:0] widx;
  logic [1:0]       lane;
  logic [31:0]      addr_hi;
  logic             req_err;
  logic             wr_en;
  logic [31:0]      raw_word;
  logic [31:0]      load_data;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;

  assign req_ready = (state_q == ST_READY) & ~reset;
  assign accept    = req_valid & req_ready;
  assign widx      = req_addr[ADDR_W-1:2];
  assign lane      = req_addr[1:0];
  assign addr_hi   = req_addr >> ADDR_W;
  assign raw_word  = mem[widx];

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = lane[0];
      SZ_WORD: req_err = |lane;
      default: req_err = 1'b1;
    endcase
    if (|addr_hi) req_err = 1'b1;
  end

  assign wr_en = accept & req_write & ~req_err;

  dmem_lane_align u_align (
    .size_i      (req_size),
    .lane_i      (lane),
    .unsigned_i  (req_unsigned),
    .rdata_i     (raw_word),
    .wdata_i     (req_wdata),
    .load_data_o (load_data),
    .be_o        (be),
    .wdata_rep_o (wdata_rep)
  );

  // Array has no reset; the clear sweep and stores are its only writers.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[idx_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][i*8 +: 8] <= wdata_rep[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      rsp_err_q   <= accept & req_err;
      rsp_rdata_q <= (accept & ~req_write & ~req_err) ? load_data : '0;
      case (state_q)
        ST_CLEAR: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == IDX_W'(DEPTH - 1)) state_q <= ST_READY;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_bytelane.sv
// tb/tb_dmem_bytelane.sv - directed scoreboard bench for dmem_bytelane
module tb_dmem_bytelane;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   run_len = 0;
  int   max_run = 0;

  always #5 clk = ~clk;

  dmem_bytelane #(.ADDR_W(9), .CLEAR_ON_RESET(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always @(negedge clk) begin
    if (rsp_valid) begin
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
      checks = checks + 1;
      assert (sb.size() != 0) else begin
        errors = errors + 1;
        $error("FAIL unexpected_rsp got rsp_valid=1 expected no response pending");
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        checks = checks + 2;
        assert (rsp_rdata === e.rdata) else begin
          errors = errors + 1;
          $error("FAIL %s rdata got %h expected %h", e.tag, rsp_rdata, e.rdata);
        end
        assert (rsp_err === e.err) else begin
          errors = errors + 1;
          $error("FAIL %s err got %b expected %b", e.tag, rsp_err, e.err);
        end
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    assert (got === exp) else begin
      errors = errors + 1;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    e.tag = tag; e.rdata = exp_rdata; e.err = exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, n, exp_cycles);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err",   {31'h0, rsp_err}, 32'h0);
    reset = 1'b0;
    wait_ready("clear_len", 128);

    send("lw_0",     1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h0, 1'b0);
    send("lw_1fc",   1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0, 32'h0, 1'b0);
    drain();

    send("sw_10",    1'b1, 2'b10, 1'b0, 32'h010, 32'h11223344, 32'h0, 1'b0);
    drain();
    send("lb_10",    1'b0, 2'b00, 1'b0, 32'h010, 32'h0, 32'h00000011, 1'b0);
    send("lbu_13",   1'b0, 2'b00, 1'b1, 32'h013, 32'h0, 32'h00000044, 1'b0);
    send("lh_12",    1'b0, 2'b01, 1'b0, 32'h012, 32'h0, 32'h00003344, 1'b0);
    drain();

    send("sw_20",    1'b1, 2'b10, 1'b0, 32'h020, 32'h80FF7F01, 32'h0, 1'b0);
    send("sb_21",    1'b1, 2'b00, 1'b0, 32'h021, 32'hFFFFFFAA, 32'h0, 1'b0);
    send("lw_20",    1'b0, 2'b10, 1'b1, 32'h020, 32'h0, 32'h80AA7F01, 1'b0);
    send("lb_20",    1'b0, 2'b00, 1'b0, 32'h020, 32'h0, 32'hFFFFFF80, 1'b0);
    send("lhu_20",   1'b0, 2'b01, 1'b1, 32'h020, 32'h0, 32'h000080AA, 1'b0);
    send("lh_20",    1'b0, 2'b01, 1'b0, 32'h020, 32'h0, 32'hFFFF80AA, 1'b0);
    send("lh_22",    1'b0, 2'b01, 1'b0, 32'h022, 32'h0, 32'h00007F01, 1'b0);
    drain();

    send("lw_22",    1'b0, 2'b10, 1'b0, 32'h022, 32'h0, 32'h0, 1'b1);
    send("sh_21",    1'b1, 2'b01, 1'b0, 32'h021, 32'h5555, 32'h0, 1'b1);
    send("sw_200",   1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678, 32'h0, 1'b1);
    send("rsvd_20",  1'b1, 2'b11, 1'b0, 32'h020, 32'h0, 32'h0, 1'b1);
    send("lb_hi",    1'b0, 2'b00, 1'b0, 32'h8000_0020, 32'h0, 32'h0, 1'b1);
    send("lw_20_ok", 1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 32'h80AA7F01, 1'b0);
    drain();

    send("sw_22h",   1'b1, 2'b01, 1'b0, 32'h022, 32'h0000BEEF, 32'h0, 1'b0);
    send("lw_22h",   1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 32'h80AABEEF, 1'b0);
    drain();

    max_run = 0;
    send("sw_30",    1'b1, 2'b10, 1'b0, 32'h030, 32'hDEADBEEF, 32'h0, 1'b0);
    send("lw_30",    1'b0, 2'b10, 1'b0, 32'h030, 32'h0, 32'hDEADBEEF, 1'b0);
    drain();
    chk("b2b_run", max_run, 2);
    chk("sb_empty", sb.size(), 0);

    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h030;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rsp_drop_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rsp_drop_rdata", rsp_rdata, 32'h0);
    chk("rst_ready2", {31'h0, req_ready}, 32'h0);
    repeat (3) @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    repeat (50) @(posedge clk); #1;
    chk("mid_clear_ready", {31'h0, req_ready}, 32'h0);
    req_valid = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    wait_ready("clear_len2", 128);

    send("lw_30_clr", 1'b0, 2'b10, 1'b0, 32'h030, 32'h0, 32'h0, 1'b0);
    send("lw_20_clr", 1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 32'h0, 1'b0);
    drain();
    chk("sb_empty_end", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised MEM-stage data memory for the 5-stage MIPS pipeline. Supports byte, halfword and word loads and stores (LB/LBU/LH/LHU/LW/SB/SH/SW) with big-endian byte lanes, byte-enable writes, a registered 1-cycle read and alignment/range error reporting. After reset, an optional sweep zeroes the whole array before the first request is accepted.

## Interface
Parameters:
- ADDR_W, 9, byte-address width decoded; DEPTH = 2**(ADDR_W-2) 32-bit words (default 128 words).
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests; 0 = contents undefined, ready immediately.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the value is taken from the low bits (byte [7:0], half [15:0]).
- rsp_valid  out  1  one-cycle pulse, one per accepted request.
- rsp_rdata  out  32  aligned and extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected (misaligned, out of range or reserved size).

## Operation
- States:
  - CLEAR: counter idx walks 0..DEPTH-1, writes 32'h0 to word idx each cycle, req_ready=0. At idx=DEPTH-1 it moves to READY.
  - READY: req_ready=1.
- CLEAR_ON_RESET=0: leave reset straight into READY.
- Accept = req_valid & req_ready. No other input is sampled.
- Word index = req_addr[ADDR_W-1:2]. Lane = req_addr[1:0].
- Big-endian lanes: lane 0 → bits 31:24, lane 3 → bits 7:0. A halfword at lane 0 → 31:16, at lane 2 → 15:0.
- Error conditions (any one sets rsp_err):
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - any req_addr[31:ADDR_W] bit set.
- On error, no array write is performed; rsp_rdata=0; rsp_valid still pulses.
- Store: a byte-enable write of only the selected lanes. Other bytes of the word are preserved.
- Load: the selected lanes are shifted to the low bits, then zero- or sign-extended per req_unsigned. Word loads ignore req_unsigned.

## Timing
- Reset values: state = CLEAR (or READY if CLEAR_ON_RESET=0), idx=0, req_ready=0 while reset is asserted, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Clear duration: req_ready rises exactly DEPTH cycles after reset deasserts (128 with defaults).
- Latency: a request accepted at edge N gives rsp_valid/rsp_rdata/rsp_err valid in the cycle after edge N, for exactly one cycle.
- Throughput: one request per cycle in READY, with no bubbles.
- Store at edge N, load of the same word at edge N+1: the load returns the stored data. No forwarding path is needed because the write commits at edge N.
- Reset asserted mid-clear or mid-response: state, idx and outputs return to their reset values immediately. The clear restarts from idx=0. A request pending at that moment is dropped with no response.
- req_ready never drops in READY except through reset.

## Structure
- Shared package mips_mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encoding ST_CLEAR, ST_READY.
  The pipeline control decoder uses the same size constants.
- Sub-module dmem_lane_align: a combinational block that, given size, lane, unsigned and raw word, produces the extracted/extended load data. It also builds the store byte-enable mask and lane-replicated write data.
- The top level contains the array, the clear FSM/counter, error decode and the response registers.

## Test plan
- Reset release, CLEAR_ON_RESET=1: req_ready low for 128 cycles, then high. A LW from 0x0 and from 0x1FC returns 0, rsp_err=0.
- SW 0x11223344 at 0x10, then LB 0x10 → 0x00000011; LBU 0x13 → 0x00000044; LH 0x12 → 0x00003344.
- SW 0x80FF7F01 at 0x20, then SB 0x000000AA at 0x21. LW 0x20 → 0x80AA7F01; LB 0x20 → 0xFFFFFF80; LHU 0x20 → 0x000080AA.
- Misaligned and out-of-range requests:
  - LW 0x22 → rsp_err=1, rsp_rdata=0;
  - SH 0x21 → rsp_err=1;
  - SW 0x200 → rsp_err=1.
  A follow-up LW 0x20 shows the word unchanged.
- Back-to-back stream of SW 0x30 ← 0xDEADBEEF then LW 0x30 on consecutive cycles → rsp_valid high two consecutive cycles; the second response returns 0xDEADBEEF.
- Assert reset at cycle 50 of the clear, release: req_ready high exactly 128 cycles after the second release. No rsp_valid is produced for a request held during reset.
